// File: rtl/gpio_axil_pkg.sv
// Shared constants for the GPIO AXI4-Lite command sequencer: opcodes, response
// status codes, GPIO slave register map and sequencer state encoding.
package gpio_axil_pkg;

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_POLL  = 2'd2;
   localparam logic [1:0] OP_DELAY = 2'd3;

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_BUSERR  = 2'd1;
   localparam logic [1:0] ST_TIMEOUT = 2'd2;

   localparam logic [3:0] REG_CH0_DATA = 4'h0;
   localparam logic [3:0] REG_CH0_DIR  = 4'h4;
   localparam logic [3:0] REG_CH1_DATA = 4'h8;
   localparam logic [3:0] REG_CH1_DIR  = 4'hC;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WR        = 3'd1;
   localparam logic [2:0] S_WR_B      = 3'd2;
   localparam logic [2:0] S_RD        = 3'd3;
   localparam logic [2:0] S_RD_R      = 3'd4;
   localparam logic [2:0] S_POLL_WAIT = 3'd5;
   localparam logic [2:0] S_DLY       = 3'd6;
   localparam logic [2:0] S_RSP       = 3'd7;

endpackage

// File: rtl/axil_single_master.sv
// Single-beat AXI4-Lite master: one read or write per start pulse, owning all
// channel handshakes. addr_done marks the request phase, done the response.
module axil_single_master
   import gpio_axil_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  start,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic                  addr_done,
   output logic                  done,
   output logic [31:0]           rdata,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [31:0]           m_axi_wdata,
   output logic [3:0]            m_axi_wstrb,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [31:0]           m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic                  w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_wr_req_done;
   logic                  w_unused_addr;

   assign w_unused_addr = ^addr[1:0];

   assign w_aw_hs = r_awvalid & m_axi_awready;
   assign w_w_hs  = r_wvalid & m_axi_wready;
   assign w_b_hs  = r_bready & m_axi_bvalid;
   assign w_ar_hs = r_arvalid & m_axi_arready;
   assign w_r_hs  = r_rready & m_axi_rvalid;

   // aw and w retire independently; the request phase ends when neither is left pending
   assign w_wr_req_done = (r_awvalid | r_wvalid) &
                          (!r_awvalid | m_axi_awready) &
                          (!r_wvalid | m_axi_wready);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
      end else begin
         if (start) begin
            r_addr    <= {addr[ADDR_WIDTH-1:2], 2'b00};
            r_wdata   <= wdata;
            r_awvalid <= we;
            r_wvalid  <= we;
            r_arvalid <= !we;
         end else begin
            if (w_aw_hs) r_awvalid <= 1'b0;
            if (w_w_hs)  r_wvalid  <= 1'b0;
            if (w_ar_hs) r_arvalid <= 1'b0;
         end
         if (w_wr_req_done)  r_bready <= 1'b1;
         else if (w_b_hs)    r_bready <= 1'b0;
         if (w_ar_hs)        r_rready <= 1'b1;
         else if (w_r_hs)    r_rready <= 1'b0;
      end
   end

   assign addr_done = w_wr_req_done | w_ar_hs;
   assign done      = w_b_hs | w_r_hs;
   assign rdata     = m_axi_rdata;
   assign err       = r_bready ? (m_axi_bresp != 2'b00) : (m_axi_rresp != 2'b00);

   assign m_axi_awaddr  = r_addr;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_wstrb   = {4{r_wvalid}};
   assign m_axi_wvalid  = r_wvalid;
   assign m_axi_bready  = r_bready;
   assign m_axi_araddr  = r_addr;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_rready  = r_rready;

endmodule

// File: rtl/gpio_axil_sequencer.sv
// Command sequencer driving a GPIO AXI4-Lite slave: write, read, poll-until-match
// with timeout, and cycle delay, one response per command.
module gpio_axil_sequencer
   import gpio_axil_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH    = 4,
   parameter int unsigned POLL_INTERVAL = 16,
   parameter int unsigned POLL_MAX      = 1024
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_data,
   input  logic [31:0]           cmd_mask,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_data,
   output logic [1:0]            rsp_status,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [31:0]           m_axi_wdata,
   output logic [3:0]            m_axi_wstrb,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [31:0]           m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   localparam logic [15:0] POLL_MAX_W = 16'(POLL_MAX);
   localparam logic [15:0] POLL_IVL_W = 16'(POLL_INTERVAL);

   logic [2:0]            r_state;
   logic                  r_run;
   logic [1:0]            r_op;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_data, r_mask;
   logic [15:0]           r_poll_cnt, r_dly_cnt, r_ivl_cnt;
   logic [31:0]           r_rsp_data;
   logic [1:0]            r_rsp_status;

   logic                  w_accept, w_start, w_we, w_addr_done, w_done, w_err, w_match;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [31:0]           w_rdata;
   logic [15:0]           w_poll_next;

   // r_run keeps cmd_ready low while reset is held, so every output resets low
   assign cmd_ready = r_run & (r_state == S_IDLE) & !rsp_valid;
   assign rsp_valid = (r_state == S_RSP);
   assign busy      = (r_state != S_IDLE);
   assign rsp_data   = r_rsp_data;
   assign rsp_status = r_rsp_status;

   assign w_accept    = cmd_valid & cmd_ready;
   assign w_start     = (w_accept & (cmd_op != OP_DELAY)) |
                        ((r_state == S_POLL_WAIT) & (r_ivl_cnt == 16'd1));
   assign w_we        = (r_state == S_IDLE) & (cmd_op == OP_WRITE);
   assign w_addr      = (r_state == S_IDLE) ? cmd_addr : r_addr;
   assign w_match     = ((w_rdata ^ r_data) & r_mask) == 32'd0;
   assign w_poll_next = r_poll_cnt + 16'd1;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state      <= S_IDLE;
         r_run        <= 1'b0;
         r_op         <= OP_WRITE;
         r_addr       <= '0;
         r_data       <= '0;
         r_mask       <= '0;
         r_poll_cnt   <= '0;
         r_dly_cnt    <= '0;
         r_ivl_cnt    <= '0;
         r_rsp_data   <= '0;
         r_rsp_status <= ST_OK;
      end else begin
         r_run <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op         <= cmd_op;
                  r_addr       <= cmd_addr;
                  r_data       <= cmd_data;
                  r_mask       <= cmd_mask;
                  r_poll_cnt   <= '0;
                  r_dly_cnt    <= cmd_data[15:0];
                  r_rsp_data   <= '0;
                  r_rsp_status <= ST_OK;
                  case (cmd_op)
                     OP_WRITE: r_state <= S_WR;
                     OP_DELAY: r_state <= (cmd_data[15:0] == 16'd0) ? S_RSP : S_DLY;
                     default:  r_state <= S_RD;
                  endcase
               end
            end
            S_WR: if (w_addr_done) r_state <= S_WR_B;
            S_WR_B: begin
               if (w_done) begin
                  r_rsp_status <= w_err ? ST_BUSERR : ST_OK;
                  r_state      <= S_RSP;
               end
            end
            S_RD: if (w_addr_done) r_state <= S_RD_R;
            S_RD_R: begin
               if (w_done) begin
                  r_rsp_data <= w_rdata;
                  if ((r_op != OP_POLL) || w_err) begin
                     r_rsp_status <= w_err ? ST_BUSERR : ST_OK;
                     r_state      <= S_RSP;
                  end else begin
                     r_poll_cnt <= w_poll_next;
                     if (w_match) begin
                        r_rsp_status <= ST_OK;
                        r_state      <= S_RSP;
                     end else if (w_poll_next == POLL_MAX_W) begin
                        r_rsp_status <= ST_TIMEOUT;
                        r_state      <= S_RSP;
                     end else begin
                        r_ivl_cnt <= POLL_IVL_W;
                        r_state   <= S_POLL_WAIT;
                     end
                  end
               end
            end
            S_POLL_WAIT: begin
               if (r_ivl_cnt == 16'd1) r_state <= S_RD;
               else                    r_ivl_cnt <= r_ivl_cnt - 16'd1;
            end
            S_DLY: begin
               if (r_dly_cnt == 16'd1) r_state <= S_RSP;
               else                    r_dly_cnt <= r_dly_cnt - 16'd1;
            end
            S_RSP: if (rsp_ready) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   axil_single_master #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_master (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .start         (w_start),
      .we            (w_we),
      .addr          (w_addr),
      .wdata         (cmd_data),
      .addr_done     (w_addr_done),
      .done          (w_done),
      .rdata         (w_rdata),
      .err           (w_err),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awprot  (m_axi_awprot),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_bresp   (m_axi_bresp),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arprot  (m_axi_arprot),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready)
   );

endmodule

// File: tb/tb_gpio_axil_sequencer.sv
// Directed bench: sequencer against a small 2-channel, 8-bit GPIO slave model.
module tb_gpio_axil_sequencer;
   import gpio_axil_pkg::*;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        cmd_valid = 1'b0, cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic [3:0]  cmd_addr = 4'd0;
   logic [31:0] cmd_data = 32'd0, cmd_mask = 32'd0;
   logic        rsp_valid, rsp_ready = 1'b0, busy;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_status;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   // GPIO slave model state
   logic       s_aw_got, s_w_got, s_wdly, s_rerr = 1'b0;
   logic [3:0] s_awaddr;
   logic [31:0] s_wdata;
   logic [7:0] gpo, gdir, g2dir, gpio2_in = 8'h00;
   logic [7:0] gpio_io_o, gpio_io_t;
   int         ar_count, axi_valid_cycles;

   int n_vec = 0, n_err = 0;

   always #5 aclk = ~aclk;

   gpio_axil_sequencer #(
      .ADDR_WIDTH    (4),
      .POLL_INTERVAL (2),
      .POLL_MAX      (4)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_addr      (cmd_addr),
      .cmd_data      (cmd_data),
      .cmd_mask      (cmd_mask),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_status    (rsp_status),
      .busy          (busy),
      .m_axi_awaddr  (awaddr),
      .m_axi_awprot  (awprot),
      .m_axi_awvalid (awvalid),
      .m_axi_awready (awready),
      .m_axi_wdata   (wdata),
      .m_axi_wstrb   (wstrb),
      .m_axi_wvalid  (wvalid),
      .m_axi_wready  (wready),
      .m_axi_bresp   (bresp),
      .m_axi_bvalid  (bvalid),
      .m_axi_bready  (bready),
      .m_axi_araddr  (araddr),
      .m_axi_arprot  (arprot),
      .m_axi_arvalid (arvalid),
      .m_axi_arready (arready),
      .m_axi_rdata   (rdata),
      .m_axi_rresp   (rresp),
      .m_axi_rvalid  (rvalid),
      .m_axi_rready  (rready)
   );

   // wready lags wvalid by a cycle so aw and w complete on different edges
   assign awready   = !s_aw_got && !bvalid;
   assign wready    = s_wdly && !s_w_got;
   assign arready   = !rvalid;
   assign bresp     = 2'b00;
   assign gpio_io_o = gpo;
   assign gpio_io_t = ~gdir;

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         s_aw_got <= 1'b0; s_w_got <= 1'b0; s_wdly <= 1'b0;
         s_awaddr <= 4'd0; s_wdata <= 32'd0;
         gpo <= 8'd0; gdir <= 8'd0; g2dir <= 8'd0;
         bvalid <= 1'b0; rvalid <= 1'b0; rdata <= 32'd0; rresp <= 2'b00;
         ar_count <= 0;
      end else begin
         s_wdly <= wvalid && !s_w_got;
         if (awvalid && awready) begin s_aw_got <= 1'b1; s_awaddr <= awaddr; end
         if (wvalid && wready) begin s_w_got <= 1'b1; s_wdata <= wdata; s_wdly <= 1'b0; end
         if (s_aw_got && s_w_got) begin
            case (s_awaddr)
               REG_CH0_DATA: gpo   <= s_wdata[7:0];
               REG_CH0_DIR:  gdir  <= s_wdata[7:0];
               REG_CH1_DIR:  g2dir <= s_wdata[7:0];
               default: ;
            endcase
            bvalid <= 1'b1; s_aw_got <= 1'b0; s_w_got <= 1'b0;
         end
         if (bvalid && bready) bvalid <= 1'b0;
         if (arvalid && arready) begin
            rvalid   <= 1'b1;
            rresp    <= s_rerr ? 2'b10 : 2'b00;
            ar_count <= ar_count + 1;
            case (araddr)
               REG_CH0_DATA: rdata <= {24'd0, gpo};
               REG_CH0_DIR:  rdata <= {24'd0, gdir};
               REG_CH1_DATA: rdata <= {24'd0, gpio2_in};
               default:      rdata <= {24'd0, g2dir};
            endcase
         end
         if (rvalid && rready) rvalid <= 1'b0;
      end
   end

   initial axi_valid_cycles = 0;
   always @(posedge aclk) if (awvalid || wvalid || arvalid) axi_valid_cycles <= axi_valid_cycles + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bound_fail(input string tag);
      n_vec++;
      n_err++;
      $error("FAIL %s: wait bound expired", tag);
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [3:0] addr,
                           input logic [31:0] data, input logic [31:0] mask);
      int n = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
      while (!cmd_ready && n < 50) begin @(posedge aclk); #1; n++; end
      if (!cmd_ready) bound_fail("cmd_accept");
      @(posedge aclk); #1;
      cmd_valid = 1'b0;
   endtask

   // cycles counts the accept edge as 1
   task automatic wait_rsp(output int cycles);
      cycles = 1;
      while (!rsp_valid && cycles < 300) begin @(posedge aclk); #1; cycles++; end
      if (!rsp_valid) bound_fail("rsp_wait");
   endtask

   task automatic ack_rsp();
      rsp_ready = 1'b1;
      @(posedge aclk); #1;
      rsp_ready = 1'b0;
      chk("cmd_ready_after_rsp", {63'd0, cmd_ready}, 64'd1);
   endtask

   initial begin
      int cyc, ar0, v0, n;
      #2;
      chk("reset_outputs", {56'd0, cmd_ready, rsp_valid, busy, awvalid, wvalid, arvalid,
                            bready, rready}, 64'd0);
      @(posedge aclk); #3 aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

      send_cmd(OP_WRITE, REG_CH0_DIR, 32'hFF, 32'd0);
      wait_rsp(cyc);
      chk("wr_dir_status", {62'd0, rsp_status}, {62'd0, ST_OK});
      ack_rsp();
      send_cmd(OP_WRITE, REG_CH0_DATA, 32'hA5, 32'd0);
      wait_rsp(cyc);
      chk("wr_data_rsp", {30'd0, rsp_status, rsp_data}, 64'd0);
      ack_rsp();
      chk("gpio_io_o", {56'd0, gpio_io_o}, 64'hA5);
      chk("gpio_io_t", {56'd0, gpio_io_t}, 64'h00);

      send_cmd(OP_READ, REG_CH0_DIR, 32'd0, 32'd0);
      wait_rsp(cyc);
      chk("rd_dir_rsp", {30'd0, rsp_status, rsp_data}, 64'h0000_00FF);
      ack_rsp();

      // Poll that succeeds on the 4th read: input flips once 3 reads are done
      ar0 = ar_count;
      send_cmd(OP_POLL, REG_CH1_DATA, 32'h01, 32'h01);
      n = 0;
      while (ar_count < ar0 + 3 && n < 200) begin @(posedge aclk); #1; n++; end
      if (ar_count < ar0 + 3) bound_fail("poll_third_read");
      gpio2_in = 8'h01;
      wait_rsp(cyc);
      chk("poll_match_rsp", {30'd0, rsp_status, rsp_data}, 64'h0000_0001);
      chk("poll_match_reads", 64'(ar_count - ar0), 64'd4);
      ack_rsp();

      gpio2_in = 8'h00;
      ar0 = ar_count;
      send_cmd(OP_POLL, REG_CH1_DATA, 32'h01, 32'h01);
      wait_rsp(cyc);
      chk("poll_timeout_rsp", {30'd0, rsp_status, rsp_data}, {30'd0, ST_TIMEOUT, 32'd0});
      chk("poll_timeout_reads", 64'(ar_count - ar0), 64'd4);
      ack_rsp();

      ar0 = ar_count;
      send_cmd(OP_POLL, REG_CH1_DATA, 32'hDEAD, 32'h0);
      wait_rsp(cyc);
      chk("poll_mask0_rsp", {30'd0, rsp_status, rsp_data}, 64'd0);
      chk("poll_mask0_reads", 64'(ar_count - ar0), 64'd1);
      ack_rsp();

      v0 = axi_valid_cycles;
      send_cmd(OP_DELAY, 4'd0, 32'd0, 32'd0);
      wait_rsp(cyc);
      chk("delay0_latency", 64'(cyc), 64'd1);
      ack_rsp();
      send_cmd(OP_DELAY, 4'd0, 32'h5, 32'd0);
      wait_rsp(cyc);
      chk("delay5_latency", 64'(cyc), 64'd6);
      for (int i = 0; i < 3; i++) begin
         @(posedge aclk); #1;
         chk("delay5_hold", {29'd0, rsp_valid, cmd_ready, rsp_status, rsp_data},
             {29'd0, 1'b1, 1'b0, ST_OK, 32'd0});
      end
      ack_rsp();
      chk("delay_no_axi", 64'(axi_valid_cycles - v0), 64'd0);

      s_rerr = 1'b1;
      send_cmd(OP_READ, REG_CH0_DATA, 32'd0, 32'd0);
      wait_rsp(cyc);
      chk("rd_buserr_rsp", {30'd0, rsp_status, rsp_data}, {30'd0, ST_BUSERR, 32'hA5});
      ack_rsp();
      s_rerr = 1'b0;

      send_cmd(OP_WRITE, REG_CH0_DATA, 32'h3C, 32'd0);
      chk("awvalid_before_reset", {62'd0, awvalid, wvalid}, 64'd3);
      aresetn = 1'b0;
      #1;
      chk("async_reset_drop", {59'd0, awvalid, wvalid, arvalid, rsp_valid, cmd_ready}, 64'd0);
      @(posedge aclk); #3 aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("ready_after_midreset", {63'd0, cmd_ready}, 64'd1);
      send_cmd(OP_WRITE, REG_CH0_DATA, 32'h5A, 32'd0);
      wait_rsp(cyc);
      chk("wr_after_reset_status", {62'd0, rsp_status}, {62'd0, ST_OK});
      ack_rsp();
      chk("gpio_io_o_after_reset", {56'd0, gpio_io_o}, 64'h5A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/gpio_axil_sequencer.md
Name: gpio_axil_sequencer

Overview:
AXI4-Lite master that runs GPIO access commands against the team's AXI4-Lite GPIO slave (channel 0/1 data and direction registers at 0x0/0x4/0x8/0xC). It accepts commands from a local controller over a valid/ready interface: single write, single read, poll-until-match with timeout, and cycle delay. It returns one response per command. It sits between a bring-up or boot FSM and the GPIO slave, so pin sequences run without a CPU.

Parameters:
ADDR_WIDTH, 4, AXI address width; matches the GPIO slave, minimum 4.
POLL_INTERVAL, 16, idle cycles between poll reads, 1..65535.
POLL_MAX, 1024, maximum poll reads before timeout, 1..65535.

Ports:
aclk  in  1  clock.
aresetn  in  1  asynchronous active-low reset.
cmd_valid  in  1  command valid.
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
cmd_op  in  2  0=WRITE, 1=READ, 2=POLL, 3=DELAY.
cmd_addr  in  ADDR_WIDTH  register byte address; bits[1:0] ignored and driven 0.
cmd_data  in  32  WRITE data, POLL expected value, or DELAY count in bits[15:0].
cmd_mask  in  32  POLL compare mask.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response accept.
rsp_data  out  32  read data or last poll data; 0 for WRITE and DELAY.
rsp_status  out  2  0=OK, 1=bus error (xRESP!=0), 2=poll timeout.
busy  out  1  high whenever state!=IDLE.
m_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master with ADDR_WIDTH addresses and 32-bit data.

Behaviour:
- Clock and reset: one clock aclk. Reset aresetn is asynchronous and active-low.
- Reset values: all outputs low; state IDLE. Reset mid-transaction drops every valid immediately and abandons the command with no response. The slave shares the reset.
- cmd_ready = (state==IDLE) && !rsp_valid. The command fields are registered on accept.
- AXI attributes: awprot and arprot are 3'b000. wstrb is 4'hF.
- States: IDLE, WR, WR_B, RD, RD_R, POLL_WAIT, DLY, RSP.
- WRITE: on the edge after accept, awvalid and wvalid rise together. Each stays high until its own handshake; aw and w may complete in different cycles. Move to WR_B when both are done. In WR_B, bready=1. On bvalid, capture status = (bresp!=0) and go to RSP.
- READ: arvalid stays high until arready. Then RD_R with rready=1. On rvalid, capture rdata and status (rresp!=0), then go to RSP.
- POLL:
  - Uses the READ sequence, then increments the read count.
  - Bus error ends the command: status 1 with the last rdata.
  - Match when (rdata & mask) == (data & mask): status 0 with rdata.
  - Otherwise, if count==POLL_MAX: status 2 with the last rdata.
  - Otherwise go to POLL_WAIT for exactly POLL_INTERVAL cycles, then re-issue the read.
  - cmd_mask=0 always matches on the first read.
- DELAY: DLY counts down from cmd_data[15:0]. rsp_valid asserts N+1 cycles after accept. N=0 gives rsp_valid on the cycle after accept. No AXI activity.
- RSP: rsp_valid and its fields are held stable until rsp_ready, then the block returns to IDLE.
  - cmd_ready reasserts on the cycle after the response handshake.
  - rsp_ready may be held high permanently.
- Handshake rules:
  - Never more than one outstanding AXI transaction.
  - AXI valids never drop before their handshake.
  - bready and rready are high only in WR_B and RD_R.
- Counters: poll count is 16 bits, delay counter 16 bits, interval counter 16 bits. No wrap occurs, because limits are checked before increment.
- Ignored input: cmd_valid is ignored while busy or while a response is pending.

Decomposition:
- Shared package gpio_axil_pkg:
  - opcode constants OP_WRITE/OP_READ/OP_POLL/OP_DELAY.
  - status constants ST_OK/ST_BUSERR/ST_TIMEOUT.
  - GPIO register offsets REG_CH0_DATA=0x0, REG_CH0_DIR=0x4, REG_CH1_DATA=0x8, REG_CH1_DIR=0xC.
  - state encoding.
- One natural sub-module: axil_single_master. It runs a single-beat AXI4-Lite read or write transaction (start, we, addr, wdata → done, rdata, err) and owns the aw/w/b/ar/r handshakes. The sequencer FSM wraps it with poll/delay logic.

Test Plan:
- Directed tests run against the GPIO slave with NUM_CHANNELS=2 and 8-bit widths.
- WRITE 0x4 data 0xFF, then WRITE 0x0 data 0xA5 → both return status 0; gpio_io_o=0xA5; gpio_io_t=0x00.
- READ 0x4 after the writes above → rsp_data=0x000000FF, status 0.
- POLL 0x8, mask 0x01, value 0x01, with gpio2_io_i driven to 0x01 after the 3rd read → response status 0, rsp_data[0]=1, exactly 4 AR handshakes seen.
- POLL with gpio2_io_i stuck at 0x00, POLL_MAX=4, POLL_INTERVAL=2 → status 2 after exactly 4 reads, rsp_data=0.
- DELAY 0 and DELAY 5 → rsp_valid 1 and 6 cycles after accept, no AXI valids asserted; hold rsp_ready low 3 cycles → rsp fields stable and cmd_ready low.
- Bus error and reset: slave model returns rresp=2'b10 → status 1. Then assert aresetn low while awvalid is high → all m_axi valids and rsp_valid go 0 asynchronously; after release, cmd_ready=1 and the next WRITE completes normally.
